// File: rtl/dcmac_rx_seg_buf_if.sv
// ----------------------------------------------------------------------------
// dcmac_rx_seg_buf_if : DCMAC rx segment input bus plus per-lane AXI outputs
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface dcmac_rx_seg_buf_if #(
  parameter int NUM_SEG = 4
);
  logic                     i_valid;
  logic [NUM_SEG*128-1:0]   i_data;
  logic [NUM_SEG-1:0]       i_ena;
  logic [NUM_SEG-1:0]       i_err;
  logic [NUM_SEG-1:0]       i_sop;
  logic [NUM_SEG-1:0]       i_eop;
  logic [NUM_SEG*4-1:0]     i_mty;
  logic [NUM_SEG*128-1:0]   m_tdata;
  logic [NUM_SEG*16-1:0]    m_tkeep;
  logic [NUM_SEG*2-1:0]     m_tuser;
  logic [NUM_SEG-1:0]       m_tlast;
  logic [NUM_SEG-1:0]       m_tvalid;
  logic [NUM_SEG-1:0]       m_tready;

  modport master (
    output i_valid, i_data, i_ena, i_err, i_sop, i_eop, i_mty, m_tready,
    input  m_tdata, m_tkeep, m_tuser, m_tlast, m_tvalid
  );

  modport slave (
    input  i_valid, i_data, i_ena, i_err, i_sop, i_eop, i_mty, m_tready,
    output m_tdata, m_tkeep, m_tuser, m_tlast, m_tvalid
  );
endinterface

`default_nettype wire

// File: rtl/dcmac_rx_seg_buf.sv
// ----------------------------------------------------------------------------
// dcmac_rx_seg_buf : DCMAC rx segments to per-lane FWFT FIFOs with overflow resync
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dcmac_rx_seg_buf #(
  parameter int NUM_SEG     = 4,
  parameter int FIFO_DEPTH  = 512,
  parameter int RESUME_FREE = 16
) (
  input  wire logic          clk,
  input  wire logic          reset,
  dcmac_rx_seg_buf_if.slave  bus,
  input  wire logic          clear_stats,
  output logic [31:0]        stat_pkts,
  output logic [31:0]        stat_bad,
  output logic [31:0]        stat_drop,
  output logic               overflow
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam int c_EW = 128 + 16 + 3;
  localparam logic [c_CW-1:0] c_DEPTH      = c_CW'(FIFO_DEPTH);
  localparam logic [c_CW-1:0] c_RESUME_MAX = c_CW'(FIFO_DEPTH - RESUME_FREE);

  localparam logic [0:0] c_ST_PASS    = 1'b0;
  localparam logic [0:0] c_ST_DISCARD = 1'b1;

  // Stage 1 input register
  logic                   r_valid;
  logic [NUM_SEG*128-1:0] r_data;
  logic [NUM_SEG-1:0]     r_ena, r_err, r_sop, r_eop;
  logic [NUM_SEG*4-1:0]   r_mty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ena   <= '0;
      r_err   <= '0;
      r_sop   <= '0;
      r_eop   <= '0;
      r_mty   <= '0;
    end else begin
      r_valid <= bus.i_valid;
      r_data  <= bus.i_data;
      r_ena   <= bus.i_ena;
      r_err   <= bus.i_err;
      r_sop   <= bus.i_sop;
      r_eop   <= bus.i_eop;
      r_mty   <= bus.i_mty;
    end
  end

  // Lane FIFO storage; the output register is included in r_count
  logic [c_EW-1:0]    r_mem   [NUM_SEG][FIFO_DEPTH];
  logic [c_AW:0]      r_wptr  [NUM_SEG];
  logic [c_AW:0]      r_rptr  [NUM_SEG];
  logic [c_CW-1:0]    r_count [NUM_SEG];
  logic [c_EW-1:0]    r_out   [NUM_SEG];
  logic [NUM_SEG-1:0] r_ovalid;
  logic [0:0]         r_state;

  logic [NUM_SEG-1:0] w_live, w_full, w_wr, w_rd, w_load;
  logic               w_resume_ok, w_first_sop, w_found;
  logic               w_any_live, w_full_hit, w_write, w_drop;
  logic [3:0]         w_n_live, w_n_eop, w_n_bad;
  logic [15:0]        w_keep;
  logic [127:0]       w_mdata;
  logic [c_EW-1:0]    w_entry [NUM_SEG];

  assign w_live     = {NUM_SEG{r_valid}} & r_ena;
  assign w_any_live = |w_live;
  assign w_full_hit = |(w_live & w_full);

  always_comb begin
    w_full      = '0;
    w_resume_ok = 1'b1;
    w_first_sop = 1'b0;
    w_found     = 1'b0;
    w_n_live    = '0;
    w_n_eop     = '0;
    w_n_bad     = '0;
    for (int s = 0; s < NUM_SEG; s++) begin
      w_full[s] = (r_count[s] == c_DEPTH);
      if (r_count[s] > c_RESUME_MAX) w_resume_ok = 1'b0;
      if (w_live[s] && !w_found) begin
        w_found     = 1'b1;
        w_first_sop = r_sop[s];
      end
      w_n_live = w_n_live + {3'b000, w_live[s]};
      w_n_eop  = w_n_eop  + {3'b000, w_live[s] & r_eop[s]};
      w_n_bad  = w_n_bad  + {3'b000, w_live[s] & r_eop[s] & r_err[s]};
    end
  end

  // mty only trims the final segment of a packet
  always_comb begin
    w_keep  = '0;
    w_mdata = '0;
    for (int s = 0; s < NUM_SEG; s++) begin
      w_keep = r_eop[s] ? (16'hFFFF >> r_mty[4*s +: 4]) : 16'hFFFF;
      for (int b = 0; b < 16; b++)
        w_mdata[8*b +: 8] = w_keep[b] ? r_data[128*s + 8*b +: 8] : 8'h00;
      w_entry[s] = {w_mdata, w_keep, r_sop[s], r_err[s], r_eop[s]};
    end
  end

  assign w_write = w_any_live &&
                   ((r_state == c_ST_PASS) ? !w_full_hit : (w_first_sop && w_resume_ok));
  assign w_drop  = w_any_live && !w_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= c_ST_PASS;
      stat_pkts <= '0;
      stat_bad  <= '0;
      stat_drop <= '0;
      overflow  <= 1'b0;
    end else begin
      if (r_state == c_ST_PASS && w_any_live && w_full_hit)
        r_state <= c_ST_DISCARD;
      else if (r_state == c_ST_DISCARD && w_write)
        r_state <= c_ST_PASS;

      if (clear_stats) begin
        stat_pkts <= '0;
        stat_bad  <= '0;
        stat_drop <= '0;
        overflow  <= 1'b0;
      end else begin
        if (w_write) begin
          stat_pkts <= stat_pkts + 32'(w_n_eop);
          stat_bad  <= stat_bad  + 32'(w_n_bad);
        end
        if (w_drop) begin
          stat_drop <= stat_drop + 32'(w_n_live);
          if (r_state == c_ST_PASS) overflow <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_wr   = '0;
    w_rd   = '0;
    w_load = '0;
    for (int s = 0; s < NUM_SEG; s++) begin
      w_wr[s]   = w_write & w_live[s];
      w_rd[s]   = r_ovalid[s] & bus.m_tready[s];
      w_load[s] = (r_wptr[s] != r_rptr[s]) && (!r_ovalid[s] || bus.m_tready[s]);
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < NUM_SEG; s++)
      if (w_wr[s]) r_mem[s][r_wptr[s][c_AW-1:0]] <= w_entry[s];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovalid <= '0;
      for (int s = 0; s < NUM_SEG; s++) begin
        r_wptr[s]  <= '0;
        r_rptr[s]  <= '0;
        r_count[s] <= '0;
        r_out[s]   <= '0;
      end
    end else begin
      for (int s = 0; s < NUM_SEG; s++) begin
        if (w_wr[s]) r_wptr[s] <= r_wptr[s] + 1'b1;
        if (w_load[s]) begin
          r_rptr[s]   <= r_rptr[s] + 1'b1;
          r_out[s]    <= r_mem[s][r_rptr[s][c_AW-1:0]];
          r_ovalid[s] <= 1'b1;
        end else if (w_rd[s]) begin
          r_ovalid[s] <= 1'b0;
        end
        case ({w_wr[s], w_rd[s]})
          2'b10:   r_count[s] <= r_count[s] + 1'b1;
          2'b01:   r_count[s] <= r_count[s] - 1'b1;
          default: r_count[s] <= r_count[s];
        endcase
      end
    end
  end

  always_comb begin
    bus.m_tdata  = '0;
    bus.m_tkeep  = '0;
    bus.m_tuser  = '0;
    bus.m_tlast  = '0;
    bus.m_tvalid = r_ovalid;
    for (int s = 0; s < NUM_SEG; s++) begin
      bus.m_tdata[128*s +: 128] = r_out[s][c_EW-1 -: 128];
      bus.m_tkeep[16*s +: 16]   = r_out[s][18:3];
      bus.m_tuser[2*s +: 2]     = r_out[s][2:1];
      bus.m_tlast[s]            = r_out[s][0];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dcmac_rx_seg_buf.sv
// ----------------------------------------------------------------------------
// tb_dcmac_rx_seg_buf : vector table plus per-lane scoreboard bench
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dcmac_rx_seg_buf;

  localparam int NSEG = 4;

  typedef struct packed {
    logic [3:0]  ena;
    logic [3:0]  sop;
    logic [3:0]  eop;
    logic [3:0]  err;
    logic [15:0] mty;
    logic [63:0] kexp;
  } vec_t;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  keep;
    logic [1:0]   user;
    logic         last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear_stats = 1'b0;
  logic [31:0] stat_pkts, stat_bad, stat_drop;
  logic        overflow;
  int          total = 0;
  int          bad = 0;
  exp_t        sbq [NSEG][$];
  vec_t        vt [16];

  dcmac_rx_seg_buf_if #(.NUM_SEG(NSEG)) bus ();

  dcmac_rx_seg_buf #(.NUM_SEG(NSEG), .FIFO_DEPTH(16), .RESUME_FREE(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .clear_stats (clear_stats),
    .stat_pkts   (stat_pkts),
    .stat_bad    (stat_bad),
    .stat_drop   (stat_drop),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    exp_t a;
    if (reset) return;
    for (int s = 0; s < NSEG; s++) begin
      if (bus.m_tvalid[s] && bus.m_tready[s]) begin
        a = {bus.m_tdata[128*s +: 128], bus.m_tkeep[16*s +: 16], bus.m_tuser[2*s +: 2], bus.m_tlast[s]};
        total++;
        if (sbq[s].size() == 0) begin
          bad++;
          $display("FAIL lane%0d_extra: got entry %h expected none", s, a);
        end else begin
          e = sbq[s].pop_front();
          if (a !== e) begin
            bad++;
            $display("FAIL lane%0d_entry: got %h expected %h", s, a, e);
          end
        end
      end
    end
  endtask

  // One clock: outputs observed on the falling edge, caller resumes 1 unit after the rising edge
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] kcalc(input logic [3:0] eop, input logic [15:0] mty);
    logic [63:0] k;
    k = '0;
    for (int s = 0; s < NSEG; s++)
      for (int b = 0; b < 16; b++)
        k[16*s + b] = !eop[s] || (b < 16 - int'(mty[4*s +: 4]));
    return k;
  endfunction

  task automatic send_beat(input logic [3:0] ena, input logic [3:0] sop, input logic [3:0] eop,
                           input logic [3:0] err, input logic [15:0] mty,
                           input logic [63:0] kexp, input bit wr);
    logic [511:0] d;
    exp_t e;
    for (int w = 0; w < 16; w++) d[32*w +: 32] = $urandom;
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    bus.i_ena   = ena;
    bus.i_sop   = sop;
    bus.i_eop   = eop;
    bus.i_err   = err;
    bus.i_mty   = mty;
    if (wr) begin
      for (int s = 0; s < NSEG; s++) begin
        if (ena[s]) begin
          e.keep = kexp[16*s +: 16];
          for (int b = 0; b < 16; b++)
            e.data[8*b +: 8] = e.keep[b] ? d[128*s + 8*b +: 8] : 8'h00;
          e.user = {sop[s], err[s]};
          e.last = eop[s];
          sbq[s].push_back(e);
        end
      end
    end
    step();
    bus.i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.i_valid = 1'b0;
    bus.i_ena   = '1;
    bus.i_sop   = '1;
    bus.i_eop   = '1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain(input string tag);
    int n;
    bus.i_valid = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size() == 0) break;
      step();
    end
    n = sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size();
    chk(tag, 64'(n), 64'd0);
    idle(4);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) vt[i] = '{4'hF, 4'h0, 4'h0, 4'h0, 16'h0000, {4{16'hFFFF}}};
    vt[0].sop = 4'h1;
    vt[5].mty = 16'h7777;
    vt[9]     = '{4'hF, 4'h0, 4'h8, 4'h0, 16'h5000, 64'h07FF_FFFF_FFFF_FFFF};
    for (int i = 10; i < 16; i++) vt[i].ena = 4'hA;
    vt[10].sop = 4'h2;
    vt[12]     = '{4'hA, 4'h0, 4'h5, 4'h0, 16'h3333, {4{16'hFFFF}}};
    vt[15]     = '{4'hA, 4'h0, 4'hA, 4'h0, 16'hF000, 64'h0001_FFFF_FFFF_FFFF};

    bus.m_tready = '1;
    idle(0);
    bus.i_data = '0;
    bus.i_err  = '0;
    bus.i_mty  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    chk("rst_tvalid", 64'(bus.m_tvalid), 64'h0);
    chk("rst_tdata_or", 64'(|bus.m_tdata), 64'h0);
    chk("rst_tkeep", 64'(bus.m_tkeep), 64'h0);
    chk("rst_stats", {stat_pkts, stat_bad | stat_drop}, 64'h0);
    chk("rst_overflow", 64'(overflow), 64'h0);

    // First-beat latency
    send_beat(4'h1, 4'h1, 4'h1, 4'h0, 16'h0003, kcalc(4'h1, 16'h0003), 1'b1);
    chk("lat_e0", 64'(bus.m_tvalid), 64'h0);
    step();
    chk("lat_e1", 64'(bus.m_tvalid), 64'h0);
    step();
    chk("lat_e2", 64'(bus.m_tvalid), 64'h1);
    drain("lat_drain");

    for (int i = 0; i < 16; i++)
      send_beat(vt[i].ena, vt[i].sop, vt[i].eop, vt[i].err, vt[i].mty, vt[i].kexp, 1'b1);
    drain("table_drain");
    chk("table_pkts", 64'(stat_pkts), 64'd4);
    chk("table_drop", 64'(stat_drop), 64'd0);

    // Overflow: lane 2 stalled, FIFO depth 16
    bus.m_tready = 4'b1011;
    for (int b = 1; b <= 16; b++)
      send_beat(4'hF, (b == 1) ? 4'h1 : 4'h0, 4'h0, 4'h0, 16'h0, {4{16'hFFFF}}, 1'b1);
    idle(2);
    chk("ovf_before", {32'(overflow), stat_drop}, 64'h0);
    send_beat(4'hF, 4'h0, 4'h0, 4'h0, 16'h0, {4{16'hFFFF}}, 1'b0);
    idle(2);
    chk("ovf_beat17", {32'(overflow), stat_drop}, {32'd1, 32'd4});
    for (int b = 18; b <= 20; b++)
      send_beat(4'hF, 4'h0, 4'h0, 4'h0, 16'h0, {4{16'hFFFF}}, 1'b0);
    idle(2);
    chk("ovf_drop20", 64'(stat_drop), 64'd16);
    bus.m_tready = 4'hF;
    send_beat(4'hF, 4'h1, 4'h0, 4'h0, 16'h0, {4{16'hFFFF}}, 1'b0);
    idle(2);
    chk("resume_notfree", 64'(stat_drop), 64'd20);
    idle(25);
    send_beat(4'hF, 4'h2, 4'h0, 4'h0, 16'h0, {4{16'hFFFF}}, 1'b0);
    send_beat(4'hC, 4'h4, 4'h0, 4'h0, 16'h0, {4{16'hFFFF}}, 1'b1);
    send_beat(4'hF, 4'h0, 4'h8, 4'h0, 16'h0, kcalc(4'h8, 16'h0), 1'b1);
    drain("resume_drain");
    chk("resume_drop", 64'(stat_drop), 64'd24);
    chk("resume_pkts", {32'(overflow), stat_pkts}, {32'd1, 32'd5});

    // Errored eop on segment 1
    send_beat(4'hF, 4'h0, 4'h2, 4'h2, 16'h0020, kcalc(4'h2, 16'h0020), 1'b1);
    step();
    step();
    chk("err_tuser1", 64'(bus.m_tuser[3:2]), 64'h1);
    chk("err_tkeep1", 64'(bus.m_tkeep[31:16]), 64'h3FFF);
    step();
    chk("err_stats", {stat_pkts, stat_bad}, {32'd6, 32'd1});
    drain("err_drain");

    // Clear coinciding with an eop write
    send_beat(4'hF, 4'h0, 4'h8, 4'h0, 16'h0, kcalc(4'h8, 16'h0), 1'b1);
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    chk("clr_pkts_bad", {stat_pkts, stat_bad}, 64'h0);
    chk("clr_drop", 64'(stat_drop), 64'h0);
    chk("clr_overflow", 64'(overflow), 64'h0);
    drain("clr_drain");

    // Reset with entries queued
    bus.m_tready = 4'h0;
    for (int b = 0; b < 5; b++)
      send_beat(4'hF, 4'h0, 4'h0, 4'h0, 16'h0, {4{16'hFFFF}}, 1'b1);
    idle(3);
    chk("prerst_tvalid", 64'(bus.m_tvalid), 64'hF);
    reset = 1'b1;
    #1;
    chk("midrst_tvalid", 64'(bus.m_tvalid), 64'h0);
    for (int s = 0; s < NSEG; s++) sbq[s].delete();
    idle(2);
    reset = 1'b0;
    bus.m_tready = 4'hF;
    send_beat(4'hF, 4'h0, 4'h0, 4'h0, 16'h0, {4{16'hFFFF}}, 1'b1);
    chk("postrst_e0", 64'(bus.m_tvalid), 64'h0);
    step();
    chk("postrst_e1", 64'(bus.m_tvalid), 64'h0);
    step();
    chk("postrst_e2", 64'(bus.m_tvalid), 64'hF);
    drain("postrst_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dcmac_rx_seg_buf.md
# dcmac_rx_seg_buf

Parametrised DCMAC receive-segment buffer. It converts NUM_SEG DCMAC rx segments into NUM_SEG independently buffered AXI streams, one per segment lane. Disabled segments are not written. Unlike the fixed four-lane version, it adds overflow detection with packet-aligned discard/resync, eop-only mty masking, and receive statistics counters. It sits between the DCMAC rx client interface and the downstream packet assembler.

## Interface
- NUM_SEG, 4: number of segment lanes, 1..8.
- FIFO_DEPTH, 512: entries per lane FIFO; power of 2, 16..4096.
- RESUME_FREE, 16: minimum free entries that every lane FIFO must have before leaving DISCARD; must be 1..FIFO_DEPTH.
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  input beat valid.
- i_data  in  NUM_SEG*128  segment s in bits [128s+127:128s].
- i_ena, i_err, i_sop, i_eop  in  NUM_SEG  per-segment flags; bit s = segment s.
- i_mty  in  NUM_SEG*4  empty-byte count, segment s in [4s+3:4s].
- m_tdata  out  NUM_SEG*128  lane output data.
- m_tkeep  out  NUM_SEG*16  lane output byte keep.
- m_tuser  out  NUM_SEG*2  lane output user field, {sop, err}.
- m_tlast, m_tvalid  out  NUM_SEG  lane output last / valid.
- m_tready  in  NUM_SEG  lane output ready.
- clear_stats  in  1  synchronous clear of counters and the sticky flag.
- stat_pkts  out  32  count of eop segments written.
- stat_bad  out  32  count of eop segments written with err=1.
- stat_drop  out  32  count of enabled segments discarded.
- overflow  out  1  sticky flag: an overflow has occurred.

## Operation
- Stage 1: all i_* inputs are registered unconditionally. Seg s is "live" when registered valid & ena[s].
- Masking of a live segment:
  - eop=1: tkeep has its low 16−mty bits set; data bytes beyond the kept bytes are zeroed. Byte 0 is bits [7:0].
  - eop=0: mty is ignored; tkeep=16'hFFFF and data passes unmasked.
- Lane FIFO s is written with {data, tkeep, {sop,err}, eop} when seg s is live and the state is PASS. There is one entry per live segment.
- Each FIFO keeps an occupancy count in 0..FIFO_DEPTH; free = FIFO_DEPTH − count. Each lane drains independently on m_tvalid & m_tready.
- State machine, evaluated on each registered beat that has at least one live segment:
  - PASS: if any lane FIFO with a live segment has free=0 (a simultaneous read on that lane does not count), the whole beat is dropped, with no partial writes. overflow is set, stat_drop += number of live segments, and the state moves to DISCARD. Otherwise the beat is written.
  - DISCARD: the beat is written and the state moves to PASS only if both hold: the lowest-indexed live segment has sop=1, and every lane has free ≥ RESUME_FREE. Otherwise the beat is dropped and stat_drop += live count.
- A packet truncated by overflow is left without eop in the FIFOs. The downstream assembler resyncs on tuser sop.
- stat_pkts += number of written segments with eop. stat_bad += number of written segments with eop & err.
- Counters wrap modulo 2^32.
- clear_stats zeroes all three counters and overflow on the next edge. An increment in the same cycle as clear_stats is lost; the result is 0.

## Timing
- Reset values:
  - all m_tvalid=0; m_tdata, m_tkeep, m_tuser, m_tlast = 0.
  - all counters = 0; overflow = 0; state = PASS; FIFOs empty; stage-1 valid = 0.
- Latency, i_* sampled at edge E0:
  - stage-1 register updated at E0.
  - FIFO write at E1.
  - m_tvalid asserts after E2 when the lane was empty (registered first-word-fall-through output).
- The output register counts as a FIFO entry, so occupancy ≤ FIFO_DEPTH.
- AXI rules:
  - m_t* hold stable while m_tvalid & !m_tready.
  - A lane at full occupancy sustains 1 entry/cycle throughput with m_tready held high.
- A simultaneous write and read on a full lane in PASS still counts as overflow; the check uses pre-read free.
- Reset asserted mid-packet empties all FIFOs immediately. After deassertion the block starts in PASS, so the first beat may be mid-packet.
- Stats and overflow update at E1, together with the write/drop decision.

## Test plan
- NUM_SEG=4, 10 beats all ena, sop on seg0 of beat 0, eop on seg3 of beat 9 with mty=5, tready=1 → each lane emits 10 entries; lane3 last tkeep=16'h07FF with bytes 11..15 zero; stat_pkts=1; first m_tvalid 2 cycles after the first sampled beat.
- ena=4'b1010 for 6 beats → only lanes 1 and 3 receive 6 entries each; lanes 0 and 2 keep m_tvalid=0.
- mty=7 with eop=0 → tkeep=16'hFFFF and data unmasked.
- FIFO_DEPTH=16, RESUME_FREE=8, lane2 tready=0, 20 full beats → overflow=1 on beat 17; the beat is fully dropped with no partial writes; stat_drop=4; state DISCARD. Then tready=1 and a beat with seg0 sop arrives once free ≥ 8 on every lane → that beat is written; earlier non-sop beats are dropped and counted.
- Eop with err=1 on seg1 → stat_bad=1, tuser[3:2]=2'b01 on lane1. Then clear_stats together with an eop → all counters 0, overflow=0.
- Reset asserted with 5 entries queued in every lane → m_tvalid=0 on all lanes immediately; after release, the first new beat appears 2 cycles after it is sampled.
